// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master = the fetch/decode side, slave = the queue itself.
`ifndef ADDR
`define ADDR 32
`endif

interface inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = `ADDR
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              v_i;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] addr_i;
  logic              stall_o;
  logic              flush_i;
  logic              stall_i;
  logic              v_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] addr_o;
  logic [CW-1:0]     count_o;

  modport master (
    output v_i, inst_i, addr_i, flush_i, stall_i,
    input  stall_o, v_o, inst_o, addr_o, count_o
  );

  modport slave (
    input  v_i, inst_i, addr_i, flush_i, stall_i,
    output stall_o, v_o, inst_o, addr_o, count_o
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {inst, addr}
// with back-pressure when full and a flush that discards everything buffered.
`ifndef ADDR
`define ADDR 32
`endif

module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int ADDR_W = `ADDR
) (
  input  logic        clk,
  input  logic        rst,
  inst_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              full;
  logic              enq;
  logic              deq;

  // Full blocks enqueue even when a dequeue frees a slot in the same cycle.
  assign full = (cnt_q == (PW + 1)'(DEPTH));
  assign enq  = q.v_i & ~full & ~q.flush_i;
  assign deq  = (cnt_q != '0) & ~q.stall_i & ~q.flush_i;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (q.flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wp_d = wp_q + PW'(1);
      if (deq) rp_d = rp_q + PW'(1);
      if (enq && !deq)      cnt_d = cnt_q + (PW + 1)'(1);
      else if (deq && !enq) cnt_d = cnt_q - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (enq) begin
        inst_q[wp_q] <= q.inst_i;
        addr_q[wp_q] <= q.addr_i;
      end
    end
  end

  assign q.stall_o = full;
  assign q.v_o     = (cnt_q != '0);
  assign q.inst_o  = inst_q[rp_q];
  assign q.addr_o  = addr_q[rp_q];
  assign q.count_o = cnt_q;
endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based model.
module tb_inst_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ent_t mq[$];

  inst_queue_if #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) bus ();
  inst_queue #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .q(bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                       input logic flush, input logic stall);
    bit full, deq, enq;
    ent_t e;
    bus.v_i = v; bus.inst_i = inst; bus.addr_i = addr;
    bus.flush_i = flush; bus.stall_i = stall;
    @(posedge clk);
    full = (mq.size() == DEPTH);
    if (flush) mq.delete();
    else begin
      deq = (mq.size() != 0) && !stall;
      enq = v && !full;
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.inst = inst; e.addr = addr;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.v_i = 1'($urandom); bus.inst_i = $urandom; bus.addr_i = $urandom;
      bus.flush_i = 1'($urandom); bus.stall_i = 1'($urandom);
      @(negedge clk);
      checks++;
      if (bus.v_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.count_o !== 3'd0 ||
          bus.inst_o !== 32'd0 || bus.addr_o !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b stall=%b cnt=%0d inst=%0h addr=%0h need all zero",
                 bus.v_o, bus.stall_o, bus.count_o, bus.inst_o, bus.addr_o);
      end
    end
    mq.delete();
    rst = 1'b0;
    drive(1'b1, 32'hABCD, 32'h55, 1'b0, 1'b1);
    checks++;
    if (bus.v_o !== 1'b1 || bus.addr_o !== 32'h55 || bus.inst_o !== 32'hABCD) begin
      failures++;
      $display("FAIL reset_first_enq: got v=%b addr=%0h inst=%0h need v=1 addr=55 inst=abcd",
               bus.v_o, bus.addr_o, bus.inst_o);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_drain: got v=%b cnt=%0d need 0 0", bus.v_o, bus.count_o);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h100 + k, k, 1'b0, 1'b0);
      checks++;
      if (bus.v_o !== 1'b1 || bus.addr_o !== 32'(k) || bus.inst_o !== 32'h100 + k ||
          bus.count_o !== 3'd1 || bus.stall_o !== 1'b0) begin
        failures++;
        $display("FAIL stream_%0d: got v=%b addr=%0h inst=%0h cnt=%0d stall=%b need 1 %0h %0h 1 0",
                 k, bus.v_o, bus.addr_o, bus.inst_o, bus.count_o, bus.stall_o, k, 32'h100 + k);
      end
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h200 + k, k, 1'b0, 1'b1);
    checks++;
    if (bus.count_o !== 3'd4 || bus.stall_o !== 1'b1 || bus.addr_o !== 32'd0) begin
      failures++;
      $display("FAIL fill_full: got cnt=%0d stall=%b addr=%0h need 4 1 0",
               bus.count_o, bus.stall_o, bus.addr_o);
    end
    drive(1'b1, 32'h204, 32'd4, 1'b0, 1'b0);
    checks++;
    if (bus.count_o !== 3'd3 || bus.stall_o !== 1'b0 || bus.addr_o !== 32'd1) begin
      failures++;
      $display("FAIL fill_release: got cnt=%0d stall=%b addr=%0h need 3 0 1",
               bus.count_o, bus.stall_o, bus.addr_o);
    end
    drive(1'b1, 32'h204, 32'd4, 1'b0, 1'b1);
    checks++;
    if (bus.count_o !== 3'd4 || bus.stall_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_accept4: got cnt=%0d stall=%b need 4 1", bus.count_o, bus.stall_o);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.v_o !== 1'b1 || bus.addr_o !== 32'(k) || bus.inst_o !== 32'h200 + k) begin
        failures++;
        $display("FAIL fill_drain_%0d: got v=%b addr=%0h inst=%0h need 1 %0h %0h",
                 k, bus.v_o, bus.addr_o, bus.inst_o, k, 32'h200 + k);
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
    end
    checks++;
    if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0) begin
      failures++;
      $display("FAIL fill_empty: got v=%b cnt=%0d need 0 0", bus.v_o, bus.count_o);
    end
  endtask

  task automatic test_wrap();
    int seen = 0;
    // Pointers start mid-ring after earlier tests, so six entries wrap them.
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h300 + k, k, 1'b0, 1'b1);
    for (int k = 3; k < 9; k++) begin
      if (bus.v_o === 1'b1) begin
        checks++;
        if (bus.addr_o !== 32'(seen) || bus.count_o > 3'd3) begin
          failures++;
          $display("FAIL wrap_order_%0d: got addr=%0h cnt=%0d need %0h <=3",
                   seen, bus.addr_o, bus.count_o, seen);
        end
        seen++;
      end
      drive(k < 6, 32'h300 + k, k, 1'b0, 1'b0);
    end
    checks++;
    if (seen !== 6 || bus.v_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_total: got popped=%0d v=%b need 6 0", seen, bus.v_o);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h400 + k, 32'h10 + k, 1'b0, 1'b1);
    drive(1'b1, 32'h402, 32'd2, 1'b1, 1'b0);
    checks++;
    if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0 || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: got v=%b cnt=%0d stall=%b need 0 0 0",
               bus.v_o, bus.count_o, bus.stall_o);
    end
    drive(1'b1, 32'h403, 32'd3, 1'b0, 1'b1);
    checks++;
    if (bus.v_o !== 1'b1 || bus.addr_o !== 32'd3 || bus.inst_o !== 32'h403 ||
        bus.count_o !== 3'd1) begin
      failures++;
      $display("FAIL flush_next: got v=%b addr=%0h inst=%0h cnt=%0d need 1 3 403 1",
               bus.v_o, bus.addr_o, bus.inst_o, bus.count_o);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h500, 32'h50, 1'b0, 1'b1);
    drive(1'b1, 32'h501, 32'h51, 1'b0, 1'b1);
    bus.v_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.v_o !== 1'b0 || bus.count_o !== 3'd0 || bus.addr_o !== 32'd0) begin
      failures++;
      $display("FAIL async_rst: got v=%b cnt=%0d addr=%0h need 0 0 0",
               bus.v_o, bus.count_o, bus.addr_o);
    end
    #1 rst = 1'b0;
    mq.delete();
    drive(1'b1, 32'h577, 32'h77, 1'b0, 1'b1);
    checks++;
    if (bus.v_o !== 1'b1 || bus.addr_o !== 32'h77 || bus.count_o !== 3'd1) begin
      failures++;
      $display("FAIL async_rst_after: got v=%b addr=%0h cnt=%0d need 1 77 1",
               bus.v_o, bus.addr_o, bus.count_o);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), $urandom, $urandom, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0));
      checks++;
      if (bus.v_o !== (mq.size() != 0) || bus.count_o !== 3'(mq.size()) ||
          bus.stall_o !== (mq.size() == DEPTH) ||
          (mq.size() != 0 && (bus.inst_o !== mq[0].inst || bus.addr_o !== mq[0].addr))) begin
        failures++;
        $display("FAIL random_%0d: got v=%b cnt=%0d stall=%b inst=%0h addr=%0h need cnt=%0d head=%0h/%0h",
                 i, bus.v_o, bus.count_o, bus.stall_o, bus.inst_o, bus.addr_o, mq.size(),
                 (mq.size() != 0) ? mq[0].inst : 32'd0, (mq.size() != 0) ? mq[0].addr : 32'd0);
      end
    end
  endtask

  initial begin
    bus.v_i = 1'b0; bus.inst_i = '0; bus.addr_i = '0;
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
